dual_grant_sequencer: RTL and testbench
=======================================

DUAL_GRANT_SEQUENCER -- requirements
Module: dual_grant_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NREQ SHALL default to 12 and SHALL give the number of requesters; only 12 is supported.
REQ-003 Parameter CNT_W SHALL default to 8 and SHALL give the width of grant_count.
REQ-004 Port clk SHALL be a 1-bit input: rising-edge clock.
REQ-005 Port rst SHALL be a 1-bit input: asynchronous reset, active high.
REQ-006 Port req_in SHALL be a 12-bit input: request pulses, one bit per requester.
REQ-007 Port pending SHALL be a 12-bit output: registered pending-request vector, driving the dual priority encoder's req input.
REQ-008 Port first SHALL be a 4-bit input: the encoder's highest-priority index over pending.
REQ-009 Port second SHALL be a 4-bit input: the encoder's next-priority index over pending.
REQ-010 Port grant_valid SHALL be a 1-bit output: grant_id is valid.
REQ-011 Port grant_ready SHALL be a 1-bit input: consumer accepts the grant.
REQ-012 Port grant_id SHALL be a 4-bit output: granted requester index, 0..11.
REQ-013 Port grant_count SHALL be a CNT_W-bit output: total grants accepted.

Function
REQ-014 The block SHALL set pending[i] at each clock edge where req_in[i]=1. A request for a bit already pending SHALL merge with it and SHALL NOT be counted twice.
REQ-015 The block SHALL treat first as valid (fv) only when first<12 and pending[first]=1.
REQ-016 The block SHALL treat second as valid (sv) only when fv=1, second<12, second!=first and pending[second]=1. Encoder outputs for an empty vector SHALL be ignored.
REQ-017 The FSM SHALL have exactly three states: IDLE, SEND_A and SEND_B.
REQ-018 In IDLE with fv=1, the block SHALL load slotA=first and slotB=second (with slotB_v=sv), clear those bits in pending, and go to SEND_A at the same edge.
REQ-019 In SEND_A, the block SHALL drive grant_valid=1 and grant_id=slotA.
REQ-020 In SEND_A on an edge with grant_ready=1, the block SHALL go to SEND_B if slotB_v=1, and to IDLE otherwise.
REQ-021 In SEND_B, the block SHALL drive grant_valid=1 and grant_id=slotB, and SHALL go to IDLE on an edge with grant_ready=1.
REQ-022 In IDLE, the block SHALL drive grant_valid=0 and grant_id=0. One IDLE bubble cycle SHALL always separate batches.
REQ-023 While grant_valid=1 and grant_ready=0, grant_id SHALL hold stable and no state SHALL advance.
REQ-024 grant_count SHALL increment by 1 on each edge with grant_valid=1 and grant_ready=1, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 If req_in[i]=1 on the edge that clears pending[i] at a batch load, set SHALL win and pending[i] SHALL stay 1.
REQ-026 Latency: a req_in pulse at edge N with the block idle and nothing pending SHALL give grant_valid=1 after edge N+1.
REQ-027 Requests arriving while in SEND_A or SEND_B SHALL only accumulate in pending, and SHALL be served at the next IDLE load.
REQ-028 The block SHALL NOT grant any index more than once per pending assertion.

Reset
REQ-029 While rst=1, the block SHALL immediately force pending=0, state=IDLE, slotA=0, slotB=0, slotB_v=0, grant_valid=0, grant_id=0 and grant_count=0, regardless of clk.
REQ-030 Reset asserted mid-batch SHALL discard any unsent grants, and they SHALL NOT be reissued after reset.
REQ-031 After rst deasserts, the first active edge SHALL behave as IDLE with pending=0.

Verification
REQ-032 Scenario: req_in=12'h000 continuously after reset -> grant_valid=0, pending=0 and grant_count=0 indefinitely.
REQ-033 Scenario: one-cycle pulse req_in=12'h024 with grant_ready=1 -> two consecutive grants, in the order given by the first and second encoder outputs, then one IDLE cycle; afterwards pending=0 and grant_count=2.
REQ-034 Scenario: req_in=12'hFFF for one cycle with grant_ready=1 -> twelve grants with distinct ids 0..11 in six batches of two, an IDLE bubble between batches, and grant_count=12.
REQ-035 Scenario: one request pending with grant_ready held 0 for 5 cycles -> grant_valid=1 with grant_id stable and grant_count unchanged; then grant_ready=1 -> exactly one acceptance.
REQ-036 Scenario: req_in[3] pulsed again on the edge where bit 3 is loaded -> bit 3 is granted twice in total; a second pulse while pending[3]=1 is still in pending -> no additional grant.
REQ-037 Scenario: rst asserted asynchronously in SEND_A, with slotB valid and grant_count=8'hFF before it -> all outputs are 0 immediately; in a separate run, one more acceptance at 8'hFF -> grant_count wraps to 8'h00.

Source files
------------

// File: rtl/dual_grant_sequencer.sv
// Dual-grant sequencer: collects request pulses into a pending vector, takes up
// to two indices per batch from an external dual priority encoder, and issues
// them one at a time over a valid/ready grant channel.
module dual_grant_sequencer #(
  parameter int unsigned NREQ  = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_in,
  output logic [NREQ-1:0]  pending,
  input  logic [3:0]       first,
  input  logic [3:0]       second,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [3:0]       grant_id,
  output logic [CNT_W-1:0] grant_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSendA = 2'd1,
    StSendB = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [NREQ-1:0]   r_pending;
  logic [NREQ-1:0]   w_pending_next;
  logic [NREQ-1:0]   w_clear;
  logic [3:0]        r_slot_a;
  logic [3:0]        w_slot_a_next;
  logic [3:0]        r_slot_b;
  logic [3:0]        w_slot_b_next;
  logic              r_slot_b_v;
  logic              w_slot_b_v_next;
  logic [CNT_W-1:0]  r_grant_count;
  logic              w_first_hit;
  logic              w_second_hit;
  logic              w_fv;
  logic              w_sv;
  logic              w_grant_valid;
  logic [3:0]        w_grant_id;

  // Qualify encoder outputs against the registered pending vector; an index
  // outside 0..NREQ-1 never matches, so empty-vector encodings are ignored.
  always_comb begin
    w_first_hit  = 1'b0;
    w_second_hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (first == 4'(i) && r_pending[i]) w_first_hit = 1'b1;
      if (second == 4'(i) && r_pending[i]) w_second_hit = 1'b1;
    end
    w_fv = w_first_hit;
    w_sv = w_fv && w_second_hit && (second != first);
  end

  // Next-state, slot loading, pending clear mask and grant outputs.
  always_comb begin
    w_state_next    = r_state;
    w_slot_a_next   = r_slot_a;
    w_slot_b_next   = r_slot_b;
    w_slot_b_v_next = r_slot_b_v;
    w_clear         = '0;
    w_grant_valid   = 1'b0;
    w_grant_id      = 4'd0;
    unique case (r_state)
      StIdle: begin
        if (w_fv) begin
          w_slot_a_next   = first;
          w_slot_b_next   = second;
          w_slot_b_v_next = w_sv;
          for (int i = 0; i < NREQ; i++) begin
            if (first == 4'(i)) w_clear[i] = 1'b1;
            if (w_sv && second == 4'(i)) w_clear[i] = 1'b1;
          end
          w_state_next = StSendA;
        end
      end
      StSendA: begin
        w_grant_valid = 1'b1;
        w_grant_id    = r_slot_a;
        if (grant_ready) w_state_next = r_slot_b_v ? StSendB : StIdle;
      end
      StSendB: begin
        w_grant_valid = 1'b1;
        w_grant_id    = r_slot_b;
        if (grant_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // A fresh request on the clearing edge wins over the clear.
    w_pending_next = (r_pending & ~w_clear) | req_in;
  end

  // State, slot, pending and acceptance-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_pending     <= '0;
      r_slot_a      <= 4'd0;
      r_slot_b      <= 4'd0;
      r_slot_b_v    <= 1'b0;
      r_grant_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pending_next;
      r_slot_a   <= w_slot_a_next;
      r_slot_b   <= w_slot_b_next;
      r_slot_b_v <= w_slot_b_v_next;
      if (w_grant_valid && grant_ready) r_grant_count <= r_grant_count + CNT_W'(1);
    end
  end

  assign pending     = r_pending;
  assign grant_valid = w_grant_valid;
  assign grant_id    = w_grant_id;
  assign grant_count = r_grant_count;

endmodule

// File: tb/tb_dual_grant_sequencer.sv
// Directed bench for dual_grant_sequencer with a lowest-index-first dual
// priority encoder model closing the loop on pending.
module tb_dual_grant_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] req_in = '0;
  logic [11:0] pending;
  logic [3:0]  first;
  logic [3:0]  second;
  logic        grant_valid;
  logic        grant_ready = 1'b0;
  logic [3:0]  grant_id;
  logic [7:0]  grant_count;

  int n_tests = 0;
  int n_fail  = 0;

  dual_grant_sequencer #(.NREQ(12), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .pending    (pending),
    .first      (first),
    .second     (second),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .grant_id   (grant_id),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  // Encoder model: lowest set index first, next lowest second, 4'hF if absent.
  always_comb begin
    first  = 4'hF;
    second = 4'hF;
    for (int i = 11; i >= 0; i--) begin
      if (pending[i]) begin
        second = first;
        first  = 4'(i);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_in      = '0;
    grant_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single-request batches until count is 0xFF; leaves IDLE with bits 0 and 4 pending.
  task automatic pump_to_ff();
    req_in      = 12'h001;
    grant_ready = 1'b1;
    repeat (510) step();
    req_in = 12'h010;
    step();
    req_in      = '0;
    grant_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    #3;
    check_eq("rst_pending", 32'(pending), 32'h000);
    check_eq("rst_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_id", 32'(grant_id), 32'd0);
    check_eq("rst_count", 32'(grant_count), 32'd0);
    do_reset();

    // No requests: nothing happens
    grant_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("idle_valid", 32'(grant_valid), 32'd0);
      check_eq("idle_pending", 32'(pending), 32'h000);
    end
    check_eq("idle_count", 32'(grant_count), 32'd0);

    // Pulse 0x024: grants 2 then 5, then bubble
    req_in = 12'h024;
    step();
    req_in = '0;
    check_eq("p24_pending", 32'(pending), 32'h024);
    check_eq("p24_valid0", 32'(grant_valid), 32'd0);
    step();
    check_eq("p24_valid_a", 32'(grant_valid), 32'd1);
    check_eq("p24_id_a", 32'(grant_id), 32'd2);
    check_eq("p24_pend_clr", 32'(pending), 32'h000);
    step();
    check_eq("p24_valid_b", 32'(grant_valid), 32'd1);
    check_eq("p24_id_b", 32'(grant_id), 32'd5);
    check_eq("p24_count1", 32'(grant_count), 32'd1);
    step();
    check_eq("p24_bubble", 32'(grant_valid), 32'd0);
    check_eq("p24_bubble_id", 32'(grant_id), 32'd0);
    check_eq("p24_count2", 32'(grant_count), 32'd2);
    step();
    check_eq("p24_after", 32'(grant_valid), 32'd0);
    check_eq("p24_pend_end", 32'(pending), 32'h000);

    // All twelve: six batches of (A,B,bubble)
    do_reset();
    grant_ready = 1'b1;
    req_in = 12'hFFF;
    step();
    req_in = '0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i % 3 == 2) begin
        check_eq("all_bubble", 32'(grant_valid), 32'd0);
      end else begin
        check_eq("all_valid", 32'(grant_valid), 32'd1);
        check_eq("all_id", 32'(grant_id), 32'(2 * (i / 3) + (i % 3)));
      end
    end
    check_eq("all_count", 32'(grant_count), 32'd12);
    check_eq("all_pending", 32'(pending), 32'h000);

    // Backpressure: grant held for 5 cycles
    do_reset();
    req_in = 12'h080;
    step();
    req_in = '0;
    step();
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", 32'(grant_valid), 32'd1);
      check_eq("bp_id", 32'(grant_id), 32'd7);
      check_eq("bp_count", 32'(grant_count), 32'd0);
      step();
    end
    grant_ready = 1'b1;
    step();
    check_eq("bp_done_valid", 32'(grant_valid), 32'd0);
    check_eq("bp_done_count", 32'(grant_count), 32'd1);
    step();
    step();
    check_eq("bp_once_count", 32'(grant_count), 32'd1);

    // Re-request on the load edge: bit 3 granted twice
    do_reset();
    grant_ready = 1'b1;
    req_in = 12'h008;
    step();
    step();
    req_in = '0;
    check_eq("rl_id1", 32'(grant_id), 32'd3);
    check_eq("rl_pending", 32'(pending), 32'h008);
    step();
    check_eq("rl_bubble", 32'(grant_valid), 32'd0);
    check_eq("rl_count1", 32'(grant_count), 32'd1);
    step();
    check_eq("rl_valid2", 32'(grant_valid), 32'd1);
    check_eq("rl_id2", 32'(grant_id), 32'd3);
    step();
    step();
    step();
    check_eq("rl_valid_end", 32'(grant_valid), 32'd0);
    check_eq("rl_count2", 32'(grant_count), 32'd2);

    // Merge: second pulse while pending[3]=1 gives no extra grant
    do_reset();
    req_in = 12'h001;
    step();
    req_in = '0;
    step();
    check_eq("mg_id0", 32'(grant_id), 32'd0);
    req_in = 12'h008;
    step();
    step();
    req_in = '0;
    check_eq("mg_pending", 32'(pending), 32'h008);
    grant_ready = 1'b1;
    step();
    check_eq("mg_count1", 32'(grant_count), 32'd1);
    step();
    check_eq("mg_id3", 32'(grant_id), 32'd3);
    for (int c = 0; c < 4; c++) step();
    check_eq("mg_valid_end", 32'(grant_valid), 32'd0);
    check_eq("mg_count2", 32'(grant_count), 32'd2);

    // Async reset in SEND_A with slotB valid and count 0xFF
    do_reset();
    pump_to_ff();
    check_eq("ar_count_ff", 32'(grant_count), 32'hFF);
    check_eq("ar_pending", 32'(pending), 32'h011);
    step();
    check_eq("ar_valid", 32'(grant_valid), 32'd1);
    check_eq("ar_id", 32'(grant_id), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_now_valid", 32'(grant_valid), 32'd0);
    check_eq("ar_now_id", 32'(grant_id), 32'd0);
    check_eq("ar_now_count", 32'(grant_count), 32'd0);
    check_eq("ar_now_pending", 32'(pending), 32'h000);
    step();
    rst = 1'b0;
    grant_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("ar_no_reissue", 32'(grant_valid), 32'd0);
    end
    check_eq("ar_post_count", 32'(grant_count), 32'd0);

    // Counter wrap
    do_reset();
    pump_to_ff();
    grant_ready = 1'b1;
    step();
    check_eq("wr_id_a", 32'(grant_id), 32'd0);
    step();
    check_eq("wr_count", 32'(grant_count), 32'h00);
    check_eq("wr_id_b", 32'(grant_id), 32'd4);
    step();
    check_eq("wr_count1", 32'(grant_count), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
